// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: decodes 11-bit frames and strips F0/E0 prefixes.
// Emits one-cycle make/break/error pulses with the final scan code held on keyboardValue.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] keyboardValue,
  output logic       keyValid,
  output logic       keyRelease,
  output logic       keyExtended,
  output logic       frameError
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             brk_pend_q, brk_pend_d;
  logic             ext_pend_q, ext_pend_d;
  logic [7:0]       key_value_q, key_value_d;
  logic             key_ext_q, key_ext_d;
  logic             key_valid_q, key_valid_d;
  logic             key_release_q, key_release_d;
  logic             frame_error_q, frame_error_d;
  logic             fall;
  logic             data_bit;

  // clk_sync_q[2] holds the previous synchronized value, used only for edge detection.
  assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_bit = data_sync_q[1];

  always_comb begin
    state_d       = state_q;
    clk_sync_d    = {clk_sync_q[1:0], ps2Clk};
    data_sync_d   = {data_sync_q[0], ps2Data};
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    timer_d       = timer_q;
    brk_pend_d    = brk_pend_q;
    ext_pend_d    = ext_pend_q;
    key_value_d   = key_value_q;
    key_ext_d     = key_ext_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    frame_error_d = 1'b0;

    if (state_q == IDLE || fall) begin
      timer_d = '0;
    end else if (timer_q != CNT_MAX) begin
      timer_d = timer_q + 1'b1;
    end

    // A stalled frame takes priority over any edge arriving in the same cycle.
    if (state_q != IDLE && timer_q == CNT_MAX) begin
      state_d       = IDLE;
      frame_error_d = 1'b1;
      brk_pend_d    = 1'b0;
      ext_pend_d    = 1'b0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_bit) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_bit;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = data_bit;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if ((^{shift_q, parity_q}) && data_bit) begin
            if (shift_q == 8'hF0) begin
              brk_pend_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_pend_d = 1'b1;
            end else begin
              key_value_d   = shift_q;
              key_ext_d     = ext_pend_q;
              key_release_d = brk_pend_q;
              key_valid_d   = ~brk_pend_q;
              brk_pend_d    = 1'b0;
              ext_pend_d    = 1'b0;
            end
          end else begin
            frame_error_d = 1'b1;
            brk_pend_d    = 1'b0;
            ext_pend_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizers reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      clk_sync_q    <= 3'b111;
      data_sync_q   <= 2'b11;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      timer_q       <= '0;
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      key_value_q   <= 8'h00;
      key_ext_q     <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      timer_q       <= timer_d;
      brk_pend_q    <= brk_pend_d;
      ext_pend_q    <= ext_pend_d;
      key_value_q   <= key_value_d;
      key_ext_q     <= key_ext_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign keyboardValue = key_value_q;
  assign keyValid      = key_valid_q;
  assign keyRelease    = key_release_q;
  assign keyExtended   = key_ext_q;
  assign frameError    = frame_error_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: drives PS/2 frames and compares observed events
// against a byte-level keyboard protocol model.
module tb_ps2_scancode_rx;

  localparam int TIMEOUT = 10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] keyboardValue;
  logic       keyValid;
  logic       keyRelease;
  logic       keyExtended;
  logic       frameError;

  int checks = 0;
  int fails  = 0;

  // Event encoding: {kind[1:0], value[7:0], extended}; kind 1=make 2=break 3=error 0=overlap
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];

  logic [7:0] m_val;
  logic       m_ext;
  logic       m_brk_pend;
  logic       m_ext_pend;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .keyboardValue(keyboardValue),
    .keyValid(keyValid),
    .keyRelease(keyRelease),
    .keyExtended(keyExtended),
    .frameError(frameError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (keyValid || keyRelease || frameError) begin
      if (keyValid + keyRelease + frameError > 1)
        obs_q.push_back({2'd0, keyboardValue, keyExtended});
      else if (keyValid)
        obs_q.push_back({2'd1, keyboardValue, keyExtended});
      else if (keyRelease)
        obs_q.push_back({2'd2, keyboardValue, keyExtended});
      else
        obs_q.push_back({2'd3, keyboardValue, keyExtended});
    end
  end

  function automatic logic [10:0] make_frame(logic [7:0] b, bit bad_par, bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Keyboard protocol model: prefixes arm flags, a code byte produces one event.
  function automatic void model_frame(logic [7:0] b, bit good);
    if (!good) begin
      exp_q.push_back({2'd3, m_val, m_ext});
      m_brk_pend = 1'b0;
      m_ext_pend = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk_pend = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext_pend = 1'b1;
    end else begin
      m_val = b;
      m_ext = m_ext_pend;
      exp_q.push_back({m_brk_pend ? 2'd2 : 2'd1, b, m_ext_pend});
      m_brk_pend = 1'b0;
      m_ext_pend = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_val      = 8'h00;
    m_ext      = 1'b0;
    m_brk_pend = 1'b0;
    m_ext_pend = 1'b0;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Data = f[i];
      repeat (15) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (30) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (15) @(negedge clk);
    end
    ps2Data = 1'b1;
  endtask

  task automatic xmit(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(make_frame(b, bad_par, bad_stop), 11);
    model_frame(b, !(bad_par || bad_stop));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({keyboardValue, keyValid, keyRelease, keyExtended, frameError} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h want 000",
               {keyboardValue, keyValid, keyRelease, keyExtended, frameError});
    end
    reset = 1'b0;
    model_reset();
    obs_q.delete();
    exp_q.delete();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make();
    xmit(8'h16, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL make_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL make_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({keyboardValue, keyExtended} !== {m_val, m_ext}) begin
      fails++;
      $display("[TB] FAIL make_held: got %h/%b want %h/%b", keyboardValue, keyExtended, m_val, m_ext);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_break();
    xmit(8'hF0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL break_prefix_silent: got %0d events want 0", obs_q.size());
    end
    xmit(8'h16, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL break_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL break_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_extended();
    xmit(8'hE0, 1'b0, 1'b0);
    xmit(8'h75, 1'b0, 1'b0);
    checks++;
    if ({keyboardValue, keyExtended} !== {m_val, m_ext}) begin
      fails++;
      $display("[TB] FAIL ext_held: got %h/%b want %h/%b", keyboardValue, keyExtended, m_val, m_ext);
    end
    xmit(8'h26, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL ext_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL ext_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity_error();
    xmit(8'hE0, 1'b0, 1'b0);
    xmit(8'h45, 1'b1, 1'b0);
    checks++;
    if ({keyboardValue, keyExtended} !== {m_val, m_ext}) begin
      fails++;
      $display("[TB] FAIL parity_held: got %h/%b want %h/%b", keyboardValue, keyExtended, m_val, m_ext);
    end
    xmit(8'h45, 1'b0, 1'b0);
    xmit(8'h1C, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL parity_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL parity_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    xmit(8'hF0, 1'b0, 1'b0);
    send_bits(make_frame(8'h5A, 1'b0, 1'b0), 5);
    repeat (TIMEOUT + 10) @(negedge clk);
    model_frame(8'h00, 1'b0);
    xmit(8'h26, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL timeout_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL timeout_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    xmit(8'hE0, 1'b0, 1'b0);
    send_bits(make_frame(8'h33, 1'b0, 1'b0), 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({keyboardValue, keyValid, keyRelease, keyExtended, frameError} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got %h want 000",
               {keyboardValue, keyValid, keyRelease, keyExtended, frameError});
    end
    xmit(8'h1E, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("[TB] FAIL midreset_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL midreset_event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] code;
    int kind;
    for (int n = 0; n < 20; n++) begin
      code = 8'($urandom);
      if (code == 8'hF0 || code == 8'hE0) code = 8'h1C;
      kind = $urandom_range(0, 5);
      case (kind)
        1: xmit(8'hF0, 1'b0, 1'b0);
        2: xmit(8'hE0, 1'b0, 1'b0);
        3: begin xmit(8'hE0, 1'b0, 1'b0); xmit(8'hF0, 1'b0, 1'b0); end
        5: xmit(8'hF0, 1'b0, 1'b0);
        default: ;
      endcase
      xmit(code, kind == 4, kind == 5);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        fails++;
        $display("[TB] FAIL random%0d_count: got %0d events want %0d", n, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("[TB] FAIL random%0d_event[%0d]: got %h want %h", n, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if ({keyboardValue, keyExtended} !== {m_val, m_ext}) begin
        fails++;
        $display("[TB] FAIL random%0d_held: got %h/%b want %h/%b", n, keyboardValue, keyExtended, m_val, m_ext);
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_error();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives raw PS/2 keyboard frames (11-bit: start, 8 data LSB-first, odd parity, stop) on the asynchronous `ps2Clk`/`ps2Data` pins and turns them into single-cycle key events. It strips `F0` (break) and `E0` (extended) prefixes and presents the final 8-bit scan code on `keyboardValue`. That output feeds the scan-code-to-bet-opcode mapper directly downstream.

## Interface
- `TIMEOUT_CYCLES`, 10000: max `clk` cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `ps2Clk`  input  1  raw PS/2 clock pin, asynchronous.
- `ps2Data`  input  1  raw PS/2 data pin, asynchronous.
- `keyboardValue`  output  8  last completed non-prefix scan code; held between events.
- `keyValid`  output  1  one-cycle pulse: make (press) event for `keyboardValue`.
- `keyRelease`  output  1  one-cycle pulse: break (release) event for `keyboardValue`.
- `keyExtended`  output  1  `E0` preceded the current code; valid with either pulse, held until the next event.
- `frameError`  output  1  one-cycle pulse: parity error, bad stop bit, or timeout.

## Operation
- Input conditioning: both pins pass through 2-FF synchronizers. A falling edge is a synchronized `ps2Clk` of 1 in the previous cycle and 0 in the current cycle. All bit sampling uses synchronized `ps2Data` in the edge cycle.
- FSM states are IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0, go to DATA and clear the bit count. A falling edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA: each falling edge shifts data into bit[count], LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on a falling edge, the frame is good if XOR(8 data bits, parity bit)=1 and data=1. Then return to IDLE.
- Byte handling for a good frame:
  - `F0`: set breakPending. No pulse.
  - `E0`: set extPending. No pulse.
  - Any other byte: load `keyboardValue`, load `keyExtended`=extPending, pulse `keyRelease` if breakPending else `keyValid`. Then clear both pending flags.
- Bad frame (parity or stop bit wrong): pulse `frameError`, clear both pending flags, leave `keyboardValue`/`keyExtended` unchanged.
- Timeout: an idle counter resets on every falling edge and increments otherwise, only while not in IDLE. When it reaches TIMEOUT_CYCLES: pulse `frameError`, go to IDLE, clear pending flags. The counter saturates and must not wrap.
- `keyValid`, `keyRelease` and `frameError` are mutually exclusive in any cycle.

## Timing
- Reset value of every output is 0. Reset also sets state=IDLE, clears bit count, shift register, timeout counter and pending flags. Synchronizer flops reset to 1 (the idle bus level), so reset alone never produces a false edge.
- Reset mid-frame aborts the frame with no pulse of any kind. The next frame is decoded normally.
- Pin-to-edge latency: a pin transition is seen as an edge 2 `clk` cycles after it reaches the synchronizer input.
- Event latency: the registered pulse, and the `keyboardValue`/`keyExtended` update, occur in the cycle after the stop-bit edge cycle. The pulse lasts exactly one cycle.
- Back-to-back frames: the FSM re-arms in IDLE at the same clock edge it leaves STOP. No dead cycle is required.
- Assumed `clk` is at least 50× the PS/2 clock rate. No minimum-pulse filtering beyond synchronization.

## Test plan
- Make code: drive frame 0x16 (parity 0, stop 1) → one `keyValid` pulse, `keyboardValue`=0x16, `keyExtended`=0, no other pulses.
- Break sequence: frames F0 then 0x16 → no pulse after F0. Exactly one `keyRelease` after 0x16 with `keyboardValue`=0x16 and `keyValid` never high.
- Extended: frames E0 then 0x75 → `keyValid` pulse, `keyboardValue`=0x75, `keyExtended`=1. A following plain 0x26 → `keyExtended`=0.
- Parity error: frame 0x45 with parity bit 1 (correct is 0) → `frameError` pulse, no `keyValid`, `keyboardValue` keeps its prior value. The next good 0x45 → `keyValid`.
- Timeout: send start plus 4 data bits, hold `ps2Clk` high for TIMEOUT_CYCLES+10 → one `frameError` pulse and FSM in IDLE. A subsequent good 0x26 → `keyValid`, `keyboardValue`=0x26.
- Reset mid-frame: assert `reset` for 1 cycle after the 5th bit → all outputs 0, no pulse. The following good 0x1E → `keyValid`, `keyboardValue`=0x1E.
